trim_gain_sequencer: RTL

//  Loads gain-compensation factors into the trim block's GPIO-style write port
//  (data word plus one-hot per-gain strobes). Arbitrates between two requesters:

---
 rtl/trim_gain_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/trim_gain_sequencer.sv
// ----------------------------------------------------------------------------
// trim_gain_sequencer
//
// Writes a set of gain-compensation factors into the trim block through its
// GPIO-style port: a data word plus one-hot per-gain write strobes. Two
// requesters compete for the port: the processor (ps) and auto-calibration
// (cal). The winner's gain vector is latched at grant. It is then written
// out one gain per cycle. The trim block commits the whole set atomically
// when it sees the strobe for the last gain. A write can optionally be held
// back until a frame boundary, so that a new gain set never lands mid-frame.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   psReq         processor load request (level)
//   psGains       processor gain vector, gain i at [i*GAIN_WIDTH +: GAIN_WIDTH]
//   psAck         one-cycle pulse: processor gain set committed
//   calReq        calibration load request (level)
//   calGains      calibration gain vector, same packing as psGains
//   calAck        one-cycle pulse: calibration gain set committed
//   frameStrobe   frame boundary pulse
//   gpioData      current gain word, zero-extended to GPIO_WIDTH
//   gainStrobes   one-hot write strobe, one bit per gain
//   busy          high whenever the sequencer is not idle
//   grantCal      1 when the current or last grant went to calibration
//   timeoutCount  saturating count of frame-sync timeouts
// ----------------------------------------------------------------------------
module trim_gain_sequencer #(
    parameter int NUM_GAINS    = 4,
    parameter int GAIN_WIDTH   = 27,
    parameter int GPIO_WIDTH   = 32,
    parameter int SYNC_ENABLE  = 1,
    parameter int SYNC_TIMEOUT = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            psReq,
    input  logic [NUM_GAINS*GAIN_WIDTH-1:0] psGains,
    output logic                            psAck,
    input  logic                            calReq,
    input  logic [NUM_GAINS*GAIN_WIDTH-1:0] calGains,
    output logic                            calAck,
    input  logic                            frameStrobe,
    output logic [GPIO_WIDTH-1:0]           gpioData,
    output logic [NUM_GAINS-1:0]            gainStrobes,
    output logic                            busy,
    output logic                            grantCal,
    output logic [7:0]                      timeoutCount
);

    localparam int VEC_W = NUM_GAINS * GAIN_WIDTH;
    // The index register also has to hold NUM_GAINS itself. That value marks
    // "all strobes issued".
    localparam int IDX_W = $clog2(NUM_GAINS + 1);
    localparam int TMR_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] IDX_ALL_SENT = IDX_W'(NUM_GAINS);
    localparam logic [TMR_W-1:0] TMR_LAST     = TMR_W'(SYNC_TIMEOUT - 1);

    // Reject configurations the packing and zero-extension cannot support.
    generate
        if (NUM_GAINS < 2) begin : g_bad_num_gains
            $error("trim_gain_sequencer: NUM_GAINS must be >= 2");
        end
        if (GAIN_WIDTH > GPIO_WIDTH) begin : g_bad_gain_width
            $error("trim_gain_sequencer: GAIN_WIDTH must not exceed GPIO_WIDTH");
        end
        if (SYNC_TIMEOUT < 1) begin : g_bad_timeout
            $error("trim_gain_sequencer: SYNC_TIMEOUT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [TMR_W-1:0]  timer;
    logic [VEC_W-1:0]  latched;
    logic              prefer_cal;

    logic              win_cal;
    logic [VEC_W-1:0]  win_gains;
    logic [GPIO_WIDTH-1:0] first_word_in;
    logic [GPIO_WIDTH-1:0] first_word_latched;
    logic [GPIO_WIDTH-1:0] cur_word;

    function automatic logic [GPIO_WIDTH-1:0] zext(input logic [GAIN_WIDTH-1:0] g);
        logic [GPIO_WIDTH-1:0] w;
        w = '0;
        w[GAIN_WIDTH-1:0] = g;
        return w;
    endfunction

    // Arbitration and word selection. On a tie, prefer_cal decides the grant.
    // It always points at the requester that was not served last. Reset
    // clears it, so the first tie goes to the processor. The word for the
    // next strobe is muxed out of the latched vector by the running index.
    always_comb begin
        if (psReq && calReq) begin
            win_cal = prefer_cal;
        end else begin
            win_cal = calReq;
        end
        win_gains = win_cal ? calGains : psGains;

        first_word_in      = zext(win_gains[GAIN_WIDTH-1:0]);
        first_word_latched = zext(latched[GAIN_WIDTH-1:0]);

        cur_word = '0;
        for (int i = 0; i < NUM_GAINS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_word = zext(latched[i*GAIN_WIDTH +: GAIN_WIDTH]);
            end
        end
    end

    // Main sequencer. The outputs are registered, so each state sets up the
    // values for the following cycle. When leaving IDLE (no sync) or SYNC,
    // the sequencer already issues strobe 0. WRITE then issues strobes
    // 1..NUM_GAINS-1. It spends one more cycle turning the strobes off and
    // raising the ack, and DONE drops the ack. Strobe i is therefore
    // visible i+1 cycles after the grant decision (without sync). The ack
    // follows NUM_GAINS+1 cycles after that decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            timer        <= '0;
            latched      <= '0;
            prefer_cal   <= 1'b0;
            gpioData     <= '0;
            gainStrobes  <= '0;
            psAck        <= 1'b0;
            calAck       <= 1'b0;
            busy         <= 1'b0;
            grantCal     <= 1'b0;
            timeoutCount <= '0;
        end else begin
            psAck  <= 1'b0;
            calAck <= 1'b0;

            case (state)
                IDLE: begin
                    if (psReq || calReq) begin
                        latched    <= win_gains;
                        grantCal   <= win_cal;
                        prefer_cal <= ~win_cal;
                        busy       <= 1'b1;
                        timer      <= '0;
                        if (SYNC_ENABLE != 0) begin
                            state <= SYNC;
                        end else begin
                            gpioData    <= first_word_in;
                            gainStrobes <= NUM_GAINS'(1);
                            idx         <= IDX_W'(1);
                            state       <= WRITE;
                        end
                    end
                end

                SYNC: begin
                    // A frame strobe wins over a timeout that expires in
                    // the same cycle. Only a real timeout is counted.
                    if (frameStrobe || (timer == TMR_LAST)) begin
                        if (!frameStrobe && (timeoutCount != 8'hFF)) begin
                            timeoutCount <= timeoutCount + 8'd1;
                        end
                        gpioData    <= first_word_latched;
                        gainStrobes <= NUM_GAINS'(1);
                        idx         <= IDX_W'(1);
                        timer       <= '0;
                        state       <= WRITE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                WRITE: begin
                    if (idx == IDX_ALL_SENT) begin
                        gainStrobes <= '0;
                        idx         <= '0;
                        if (grantCal) begin
                            calAck <= 1'b1;
                        end else begin
                            psAck <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        gpioData    <= cur_word;
                        gainStrobes <= NUM_GAINS'(1) << idx;
                        idx         <= idx + IDX_W'(1);
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
